// File: rtl/sprite_blitter_if.sv
// Sprite blitter bus bundle: sprite ROM read port plus the valid/ready pixel stream.
// The master side belongs to the blitter; the slave side is the ROM and pixel sink.
interface sprite_blitter_if;
  logic [11:0] rom_addr;
  logic [3:0]  rom_data;
  logic        pix_valid;
  logic        pix_ready;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic [3:0]  pix_color;

  modport master (
    output rom_addr,
    input  rom_data,
    output pix_valid,
    input  pix_ready,
    output pix_x,
    output pix_y,
    output pix_color
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    input  pix_valid,
    output pix_ready,
    input  pix_x,
    input  pix_y,
    input  pix_color
  );
endinterface

// File: rtl/sprite_blitter.sv
// Sprite blitter: walks a SPR_W x SPR_H sprite from a one-cycle-latency ROM and emits
// clipped, non-transparent pixels on a valid/ready stream, optionally mirrored horizontally.
module sprite_blitter #(
  parameter int         SPR_W  = 40,
  parameter int         SPR_H  = 80,
  parameter int         SCR_W  = 640,
  parameter int         SCR_H  = 480,
  parameter logic [3:0] TRANSP = 4'h0
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              start,
  input  logic [9:0]        sprite_x,
  input  logic [9:0]        sprite_y,
  input  logic              mirror,
  sprite_blitter_if.master  bus,
  output logic              busy,
  output logic              done
);

  localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRAW  = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  function automatic logic [11:0] addr_of(input logic [RW-1:0] row,
                                          input logic [CW-1:0] col,
                                          input logic          mir);
    logic [11:0] eff_col;
    if (mir) begin
      eff_col = 12'(SPR_W - 1) - 12'(col);
    end else begin
      eff_col = 12'(col);
    end
    return 12'(row) * 12'(SPR_W) + eff_col;
  endfunction

  logic [1:0]    state_r;
  logic [9:0]    sx_r;
  logic [9:0]    sy_r;
  logic          mir_r;
  logic [RW-1:0] row_r;
  logic [CW-1:0] col_r;
  logic [11:0]   rom_addr_r;
  logic          stg_valid_r;
  logic [RW-1:0] stg_row_r;
  logic [CW-1:0] stg_col_r;
  logic          stg_fresh_r;
  logic [3:0]    color_r;
  logic          busy_r;
  logic          done_r;

  logic [3:0]    color_s;
  logic [10:0]   px_s;
  logic [10:0]   py_s;
  logic          show_s;
  logic          retire_s;
  logic          last_s;
  logic [RW-1:0] nxt_row_s;
  logic [CW-1:0] nxt_col_s;

  // rom_data matches the stage only on the first cycle after a load (rom_addr already moved on),
  // so a stalled pixel keeps its colour from the captured copy.
  always_comb begin
    color_s = color_r;
    if (stg_fresh_r) begin
      color_s = bus.rom_data;
    end else begin
      color_s = color_r;
    end
  end

  // Screen position, visibility and stage retirement for the staged pixel.
  always_comb begin
    px_s     = 11'(sx_r) + 11'(stg_col_r);
    py_s     = 11'(sy_r) + 11'(stg_row_r);
    show_s   = stg_valid_r && (color_s != TRANSP) &&
               (px_s < 11'(SCR_W)) && (py_s < 11'(SCR_H));
    retire_s = !stg_valid_r || !show_s || bus.pix_ready;
    last_s   = (row_r == RW'(SPR_H - 1)) && (col_r == CW'(SPR_W - 1));
  end

  // Row-major walk successor of the position currently on rom_addr.
  always_comb begin
    nxt_row_s = row_r;
    nxt_col_s = col_r;
    if (col_r == CW'(SPR_W - 1)) begin
      nxt_col_s = '0;
      nxt_row_s = row_r + RW'(1);
    end else begin
      nxt_col_s = col_r + CW'(1);
      nxt_row_s = row_r;
    end
  end

  // Control FSM, walk counters, ROM address and pixel stage.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r     <= IDLE;
      sx_r        <= '0;
      sy_r        <= '0;
      mir_r       <= 1'b0;
      row_r       <= '0;
      col_r       <= '0;
      rom_addr_r  <= '0;
      stg_valid_r <= 1'b0;
      stg_row_r   <= '0;
      stg_col_r   <= '0;
      stg_fresh_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            sx_r       <= sprite_x;
            sy_r       <= sprite_y;
            mir_r      <= mirror;
            row_r      <= '0;
            col_r      <= '0;
            rom_addr_r <= addr_of(RW'(0), CW'(0), mirror);
            busy_r     <= 1'b1;
            state_r    <= DRAW;
          end else begin
            state_r <= IDLE;
          end
        end
        DRAW: begin
          if (retire_s) begin
            stg_valid_r <= 1'b1;
            stg_row_r   <= row_r;
            stg_col_r   <= col_r;
            stg_fresh_r <= 1'b1;
            if (last_s) begin
              state_r <= FLUSH;
            end else begin
              row_r      <= nxt_row_s;
              col_r      <= nxt_col_s;
              rom_addr_r <= addr_of(nxt_row_s, nxt_col_s, mir_r);
            end
          end else begin
            stg_fresh_r <= 1'b0;
          end
        end
        FLUSH: begin
          if (retire_s) begin
            stg_valid_r <= 1'b0;
            stg_fresh_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b1;
            state_r     <= IDLE;
          end else begin
            stg_fresh_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= IDLE;
          stg_valid_r <= 1'b0;
          stg_fresh_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  // Colour capture for the staged pixel.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      color_r <= 4'h0;
    end else if (stg_fresh_r) begin
      color_r <= bus.rom_data;
    end else begin
      color_r <= color_r;
    end
  end

  assign bus.rom_addr  = rom_addr_r;
  assign bus.pix_valid = show_s;
  assign bus.pix_x     = px_s[9:0];
  assign bus.pix_y     = py_s[9:0];
  assign bus.pix_color = color_s;
  assign busy          = busy_r;
  assign done          = done_r;

endmodule

// File: tb/tb_sprite_blitter.sv
// Self-checking bench for sprite_blitter: a queue-based reference model of the expected
// pixel stream, checked beat by beat under random and directed pix_ready patterns.
module tb_sprite_blitter;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       start = 1'b0;
  logic [9:0] sprite_x = 10'd0;
  logic [9:0] sprite_y = 10'd0;
  logic       mirror = 1'b0;
  logic       busy;
  logic       done;

  sprite_blitter_if bus();

  sprite_blitter #(
    .SPR_W(40), .SPR_H(80), .SCR_W(640), .SCR_H(480), .TRANSP(4'h0)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .mirror(mirror),
    .bus(bus), .busy(busy), .done(done)
  );

  always #5 Clk = ~Clk;

  logic [3:0] mem [0:4095];

  // Synchronous ROM: data for an address appears one cycle after it is presented.
  always @(posedge Clk) bus.rom_data <= mem[bus.rom_addr];

  int n_checks = 0;
  int n_errors = 0;
  logic [23:0] exp_q [$];
  int beats = 0;
  int done_cnt = 0;
  int rmode = 0;
  bit stall_armed = 1'b0;
  int stall_left = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected beats: every position in row-major order, ROM word chosen by mirror, then
  // dropped if transparent or off-screen.
  task automatic build_model(input logic [9:0] x, input logic [9:0] y, input bit mir);
    exp_q.delete();
    for (int r = 0; r < 80; r++) begin
      for (int c = 0; c < 40; c++) begin
        int a;
        int px;
        int py;
        logic [9:0] px10;
        logic [9:0] py10;
        a  = r * 40 + (mir ? (39 - c) : c);
        px = int'(x) + c;
        py = int'(y) + r;
        px10 = px[9:0];
        py10 = py[9:0];
        if (mem[a] != 4'h0 && px < 640 && py < 480)
          exp_q.push_back({px10, py10, mem[a]});
      end
    end
  endtask

  // pix_ready driver: always ready, random, or a 5-cycle stall on pixel (120,53).
  initial begin
    bus.pix_ready = 1'b1;
    forever begin
      @(posedge Clk);
      #1;
      case (rmode)
        0: bus.pix_ready = 1'b1;
        1: bus.pix_ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (stall_armed && bus.pix_valid && bus.pix_x == 10'd120 && bus.pix_y == 10'd53) begin
            stall_armed = 1'b0;
            stall_left  = 5;
          end
          if (stall_left > 0) begin
            bus.pix_ready = 1'b0;
            stall_left--;
          end else begin
            bus.pix_ready = 1'b1;
          end
        end
        default: bus.pix_ready = 1'b1;
      endcase
    end
  end

  // Output monitor: scoreboard on accepted beats, hold-stability under backpressure, done pulses.
  initial begin
    logic [63:0] snap;
    logic [63:0] cur;
    bit stalled_prev;
    stalled_prev = 1'b0;
    snap = '0;
    forever begin
      @(negedge Clk);
      cur = {27'd0, bus.pix_valid, bus.pix_x, bus.pix_y, bus.pix_color, bus.rom_addr};
      if (!Reset_n) begin
        stalled_prev = 1'b0;
      end else begin
        if (stalled_prev) check_eq("stall_hold", cur, snap);
        if (bus.pix_valid && bus.pix_ready) begin
          beats++;
          check_eq("beat_expected", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0)
            check_eq("beat", 64'({bus.pix_x, bus.pix_y, bus.pix_color}), 64'(exp_q.pop_front()));
        end
        stalled_prev = bus.pix_valid && !bus.pix_ready;
        snap = cur;
        if (done) begin
          done_cnt++;
          check_eq("done_busy_low", 64'(busy), 64'd0);
        end
      end
    end
  end

  // One draw: start pulse now (caller sits just after a rising edge), run to done or abort point.
  task automatic do_draw(input logic [9:0] x, input logic [9:0] y, input bit mir,
                         input int mode, input int exp_beats, input int first_exp,
                         input int done_exp, input bit inject, input int abort_at);
    int cyc;
    int first;
    int model_n;
    build_model(x, y, mir);
    model_n  = exp_q.size();
    rmode    = mode;
    beats    = 0;
    done_cnt = 0;
    sprite_x = x;
    sprite_y = y;
    mirror   = mir;
    start    = 1'b1;
    cyc      = 0;
    first    = -1;
    @(posedge Clk);
    #1;
    start = 1'b0;
    cyc   = 1;
    check_eq("busy_after_start", 64'(busy), 64'd1);
    while (!done && cyc < 20000 && !(abort_at >= 0 && beats >= abort_at)) begin
      if (inject && cyc == 500) begin
        start    = 1'b1;
        sprite_x = ~x;
        sprite_y = ~y;
        mirror   = ~mir;
      end else begin
        start = 1'b0;
      end
      @(posedge Clk);
      #1;
      cyc++;
      if (first < 0 && bus.pix_valid) first = cyc;
    end
    start = 1'b0;
    if (abort_at >= 0) begin
      check_eq("abort_reached", 64'(beats >= abort_at), 64'd1);
      Reset_n = 1'b0;
      #1;
      check_eq("rst_pix_valid", 64'(bus.pix_valid), 64'd0);
      check_eq("rst_pix_x", 64'(bus.pix_x), 64'd0);
      check_eq("rst_pix_y", 64'(bus.pix_y), 64'd0);
      check_eq("rst_busy", 64'(busy), 64'd0);
      check_eq("rst_done", 64'(done), 64'd0);
      check_eq("rst_rom_addr", 64'(bus.rom_addr), 64'd0);
      repeat (2) @(posedge Clk);
      #1;
      Reset_n = 1'b1;
    end else begin
      check_eq("done_seen", 64'(done), 64'd1);
      check_eq("busy_at_done", 64'(busy), 64'd0);
      if (first_exp >= 0) check_eq("first_pix_latency", 64'(first), 64'(first_exp));
      if (done_exp >= 0) check_eq("done_latency", 64'(cyc), 64'(done_exp));
      @(posedge Clk);
      #1;
      check_eq("done_single", 64'(done), 64'd0);
      repeat (2) @(posedge Clk);
      #1;
      check_eq("done_pulses", 64'(done_cnt), 64'd1);
      check_eq("idle_after", 64'(busy), 64'd0);
      check_eq("beats_left", 64'(exp_q.size()), 64'd0);
      check_eq("beat_count", 64'(beats), 64'(exp_beats >= 0 ? exp_beats : model_n));
    end
    rmode = 0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 4'h0;
    Reset_n = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check_eq("reset_busy", 64'(busy), 64'd0);
    check_eq("reset_done", 64'(done), 64'd0);
    check_eq("reset_pix_valid", 64'(bus.pix_valid), 64'd0);
    check_eq("reset_pix_x", 64'(bus.pix_x), 64'd0);
    check_eq("reset_pix_y", 64'(bus.pix_y), 64'd0);
    check_eq("reset_rom_addr", 64'(bus.rom_addr), 64'd0);
    Reset_n = 1'b1;

    // Opaque sprite, plain and mirrored, fully on screen: one position per cycle.
    for (int i = 0; i < 3200; i++) mem[i] = 4'($urandom_range(1, 15));
    do_draw(10'd100, 10'd50, 1'b0, 0, 3200, 2, 3202, 1'b0, -1);
    do_draw(10'd100, 10'd50, 1'b1, 0, 3200, 2, 3202, 1'b0, -1);
    // Clipped at the bottom-right corner: fewer beats, same duration.
    do_draw(10'd620, 10'd440, 1'b0, 0, 800, 2, 3202, 1'b0, -1);
    // Five-cycle backpressure in the middle of row 3.
    stall_armed = 1'b1;
    do_draw(10'd100, 10'd50, 1'b0, 2, 3200, 2, 3207, 1'b0, -1);
    check_eq("stall_applied", 64'(stall_armed), 64'd0);

    // Even words transparent, plus a start pulse with different inputs during the draw.
    for (int i = 0; i < 3200; i++) mem[i] = (i % 2 == 0) ? 4'h0 : 4'($urandom_range(1, 15));
    do_draw(10'd100, 10'd50, 1'b0, 0, 1600, 3, 3202, 1'b1, -1);

    // Reset part-way through, then restart on the first edge after release.
    for (int i = 0; i < 3200; i++) mem[i] = 4'($urandom_range(1, 15));
    do_draw(10'd100, 10'd50, 1'b0, 0, -1, -1, -1, 1'b0, 1000);
    do_draw(10'd100, 10'd50, 1'b0, 0, 3200, 2, 3202, 1'b0, -1);

    // Random sprites, positions, mirror and backpressure.
    for (int t = 0; t < 3; t++) begin
      logic [9:0] rx;
      logic [9:0] ry;
      for (int i = 0; i < 3200; i++)
        mem[i] = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      rx = 10'($urandom_range(0, 680));
      ry = 10'($urandom_range(0, 500));
      do_draw(rx, ry, 1'($urandom_range(0, 1)), 1, -1, -1, -1, 1'b0, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
